// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch responder between the PC and decode.
// Accepts fetch addresses, issues 1-cycle-latency reads to instruction
// memory, queues {pc, instr} entries in order and presents them to decode.
// A flush discards everything queued or in flight.
// Optional feature: define FETCHQ_ALIGN_CHK_EN to enable the sticky
// misaligned-address flag (misalign_err); otherwise it is tied low.
module fetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               flush,
  output logic               misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + INSTR_W;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              vld_p1;
  logic [ADDR_W-1:0] infl_pc_p1;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head;
  logic              acc;
  logic              push;
  logic              pop;

  // The in-flight read already holds a slot, so a return can never overflow.
  // Pop is deliberately left out to keep id_ready off the pc_ready path.
  assign pc_ready   = ~rst & ~flush &
                      (({1'b0, count} + {{CW{1'b0}}, vld_p1}) < DEPTH_W);
  assign acc        = pc_valid & pc_ready;
  assign imem_rd_en = acc;
  assign imem_addr  = pc_in;

  assign id_valid = (count != '0);
  assign push     = vld_p1;
  assign pop      = id_valid & id_ready;

  // Outputs read as zero while empty so the unreset storage never leaks out.
  assign head     = mem[rd_ptr];
  assign id_pc    = id_valid ? head[EW-1:INSTR_W] : '0;
  assign id_instr = id_valid ? head[INSTR_W-1:0]  : '0;

  // Stage p0 -> p1: control state (occupancy, pointers, in-flight valid).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= acc;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage p1 -> queue: capture the in-flight address and store returned data.
  always_ff @(posedge clk) begin
    if (acc) infl_pc_p1 <= pc_in;
    if (push && !rst && !flush) mem[wr_ptr] <= {infl_pc_p1, imem_data};
  end

`ifdef FETCHQ_ALIGN_CHK_EN
  // Sticky flag for any accepted address that is not word aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (acc && (pc_in[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_queue;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
`ifdef FETCHQ_ALIGN_CHK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ADDR_W-1:0]  pc_in = '0;
  logic               pc_valid = 1'b0;
  logic               pc_ready;
  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data = 32'hDEADBEEF;
  logic               id_valid;
  logic               id_ready = 1'b0;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic               flush = 1'b0;
  logic               misalign_err;

  int tests = 0;
  int fails = 0;

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .flush(flush),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Instruction memory: returns 0xA0000000 + address one cycle after a read,
  // and garbage otherwise so stray pushes are visible.
  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= 32'hA0000000 + {{(INSTR_W-ADDR_W){1'b0}}, imem_addr};
    else            imem_data <= 32'hDEADBEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of entries plus one in-flight slot.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  ent_t              mq[$];
  bit                m_infl = 0;
  logic [ADDR_W-1:0] m_infl_pc = '0;
  bit                m_err = 0;
  bit                m_rst_state = 0;
  bit                started = 0;

  function automatic bit exp_ready();
    return !rst && !flush && ((mq.size() + int'(m_infl)) < DEPTH);
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = pc_valid && exp_ready();
    started <= 1;
    if (rst) begin
      mq.delete();
      m_infl = 0;
      m_err = 0;
      m_rst_state = 1;
    end else begin
      m_rst_state = 0;
      if (flush) begin
        mq.delete();
        m_infl = 0;
      end else begin
        if (mq.size() > 0 && id_ready) void'(mq.pop_front());
        if (m_infl) mq.push_back({m_infl_pc, 32'hA0000000 + {{(INSTR_W-ADDR_W){1'b0}}, m_infl_pc}});
        if (acc && ALIGN_EN && pc_in[1:0] != 2'b00) m_err = 1;
        m_infl = acc;
        m_infl_pc = pc_in;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("pc_ready", pc_ready, exp_ready());
      check("imem_rd_en", imem_rd_en, pc_valid && exp_ready());
      if (pc_valid && exp_ready()) check("imem_addr", imem_addr, pc_in);
      check("id_valid", id_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("id_pc", id_pc, mq[0].pc);
        check("id_instr", id_instr, mq[0].instr);
      end
      if (m_rst_state) begin
        check("rst_id_pc", id_pc, 0);
        check("rst_id_instr", id_instr, 0);
      end
      check("misalign_err", misalign_err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_cnt;
    int pops;
    bit a;
    logic [ADDR_W-1:0] addr;

    // Reset
    step(); step();
    @(negedge clk);
    check("lit_rst_pc_ready", pc_ready, 0);
    check("lit_rst_id_valid", id_valid, 0);
    check("lit_rst_err", misalign_err, 0);
    step();

    // Three back-to-back fetches, decode always ready
    rst = 0; pc_valid = 1; pc_in = 8'h00; id_ready = 1;
    @(negedge clk);
    check("lit_t1_ready_after_rst", pc_ready, 1);
    step();                       // E0 accepts 0x00
    pc_in = 8'h04;
    @(negedge clk);
    check("lit_t1_not_yet", id_valid, 0);
    step();                       // E1 writes 0x00
    pc_in = 8'h08;
    @(negedge clk);
    check("lit_t1_v0", id_valid, 1);
    check("lit_t1_pc0", id_pc, 8'h00);
    check("lit_t1_in0", id_instr, 32'hA0000000);
    step();
    pc_valid = 0;
    @(negedge clk);
    check("lit_t1_pc1", id_pc, 8'h04);
    check("lit_t1_in1", id_instr, 32'hA0000004);
    step();
    @(negedge clk);
    check("lit_t1_pc2", id_pc, 8'h08);
    check("lit_t1_in2", id_instr, 32'hA0000008);
    step();
    @(negedge clk);
    check("lit_t1_empty", id_valid, 0);

    // Fill with decode stalled
    step();
    id_ready = 0; pc_valid = 1; addr = 8'h00; acc_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      pc_in = addr;
      @(negedge clk);
      a = pc_ready;
      step();
      if (a) begin acc_cnt++; addr = addr + 8'h04; end
    end
    check("lit_t2_accepts", acc_cnt, 4);
    @(negedge clk);
    check("lit_t2_full_ready", pc_ready, 0);
    pc_valid = 0;
    step();
    id_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_t2_drain_pc", id_pc, 8'(4 * i));
      step();
      if (i == 0) check("lit_t2_ready_back", pc_ready, 1);
    end
    step();

    // Sustained traffic with random decode stalls, across pointer wrap
    pc_valid = 1; addr = 8'h20; acc_cnt = 0; pops = 0;
    for (int c = 0; c < 200 && acc_cnt < 12; c++) begin
      pc_in = addr;
      id_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      a = pc_ready;
      if (id_valid && id_ready) pops++;
      step();
      if (a) begin acc_cnt++; addr = addr + 8'h04; end
    end
    pc_valid = 0; id_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (id_valid) pops++;
      step();
    end
    check("lit_t3_accepts", acc_cnt, 12);
    check("lit_t3_pops", pops, 12);

    // Flush with two queued entries and 0x10 in flight
    id_ready = 0; pc_valid = 1; pc_in = 8'h00;
    step();
    pc_in = 8'h04;
    step();
    pc_in = 8'h10;
    step();
    pc_valid = 0; flush = 1; id_ready = 1;
    @(negedge clk);
    check("lit_t4_flush_ready", pc_ready, 0);
    check("lit_t4_flush_rd", imem_rd_en, 0);
    step();
    flush = 0;
    @(negedge clk);
    check("lit_t4_empty", id_valid, 0);
    pc_valid = 1; pc_in = 8'h40;
    step();
    pc_valid = 0;
    step();
    @(negedge clk);
    check("lit_t4_first_v", id_valid, 1);
    check("lit_t4_first_pc", id_pc, 8'h40);
    step();

    // Misaligned address: sticky across flush, cleared by reset
    id_ready = 0; pc_valid = 1; pc_in = 8'h06;
    step();
    pc_valid = 0;
    @(negedge clk);
    check("lit_t5_err_set", misalign_err, ALIGN_EN);
    flush = 1;
    step();
    flush = 0;
    @(negedge clk);
    check("lit_t5_err_flush", misalign_err, ALIGN_EN);
    pc_valid = 1; pc_in = 8'h08;
    step(); step();
    pc_valid = 0; rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("lit_t5_err_rst", misalign_err, 0);
    check("lit_t5_rst_empty", id_valid, 0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
